router_out_fifo: RTL and testbench

Per-port output buffer of the 1x3 router. One instance sits downstream of `router_sync` for each destination (0, 1, 2). It stores packet bytes written under `write_en[i]`, tags header bytes, and tracks each packet's remaining length while it drains to the receiving client. It reports `full` and `empty` back to `router_sync`, and is flushed by that block's `soft_rst_i` time-out.

---
 rtl/router_out_fifo.sv | 97 +++++++++
 tb/tb_router_out_fifo.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/router_out_fifo.sv
// rtl/router_out_fifo.sv - per-port output FIFO of the 1x3 router with header tagging and packet length tracking
module router_out_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_in,
    input  logic             soft_rst,
    input  logic             write_en,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    input  logic             read_en,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

    logic [WIDTH:0]   mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      occ_q, occ_d;
    logic [6:0]       pkt_cnt_q, pkt_cnt_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             push, pop;
    logic [WIDTH:0]   rd_word;

    // Flags come from pre-edge occupancy only, so wrap never confuses them.
    assign full     = (occ_q == OCC_FULL);
    assign empty    = (occ_q == '0);
    assign push     = write_en && !full;
    assign pop      = read_en && !empty;
    assign rd_word  = mem_q[rd_ptr_q];
    assign data_out = data_out_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        pkt_cnt_d  = pkt_cnt_q;
        data_out_d = data_out_q;
        if (soft_rst) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            occ_d      = '0;
            pkt_cnt_d  = '0;
            data_out_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ_d = occ_q + 1'b1;
                2'b01:   occ_d = occ_q - 1'b1;
                default: occ_d = occ_q;
            endcase
            if (pop) begin
                data_out_d = rd_word[WIDTH-1:0];
                // Header length covers the payload; +1 accounts for the parity byte.
                if (rd_word[WIDTH]) begin
                    pkt_cnt_d = {1'b0, rd_word[7:2]} + 7'd1;
                end else if (pkt_cnt_q != '0) begin
                    pkt_cnt_d = pkt_cnt_q - 7'd1;
                end
            end else if (pkt_cnt_q == '0) begin
                data_out_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            pkt_cnt_q  <= '0;
            data_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            pkt_cnt_q  <= pkt_cnt_d;
            data_out_q <= data_out_d;
        end
    end

    // Storage is never cleared; a flush only resets the pointers.
    always_ff @(posedge clk) begin
        if (push && !soft_rst) begin
            mem_q[wr_ptr_q] <= {lfd_state, data_in};
        end
    end
endmodule

// File: tb/tb_router_out_fifo.sv
// tb/tb_router_out_fifo.sv - directed vector bench for router_out_fifo
module tb_router_out_fifo;
    logic       clk = 1'b0;
    logic       reset_in = 1'b1;
    logic       soft_rst = 1'b0;
    logic       write_en = 1'b0;
    logic       lfd_state = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       read_en = 1'b0;
    logic [7:0] data_out;
    logic       full;
    logic       empty;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       we;
        logic       lfd;
        logic [7:0] din;
        logic       re;
        logic       srst;
        logic [7:0] dout;
        logic       full;
        logic       empty;
    } vec_t;

    vec_t tbl[14];

    router_out_fifo #(.DEPTH(16), .WIDTH(8)) dut (
        .clk      (clk),
        .reset_in (reset_in),
        .soft_rst (soft_rst),
        .write_en (write_en),
        .lfd_state(lfd_state),
        .data_in  (data_in),
        .read_en  (read_en),
        .data_out (data_out),
        .full     (full),
        .empty    (empty)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic we, logic lfd, logic [7:0] din, logic re, logic srst,
                                logic [7:0] dout, logic f, logic e);
        vec_t v;
        v.we = we; v.lfd = lfd; v.din = din; v.re = re; v.srst = srst;
        v.dout = dout; v.full = f; v.empty = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] dout_exp, input logic full_exp,
                         input logic empty_exp);
        n_vec++;
        if (data_out !== dout_exp || full !== full_exp || empty !== empty_exp) begin
            n_err++;
            $display("FAIL %s: got dout=%h full=%b empty=%b, want dout=%h full=%b empty=%b",
                     name, data_out, full, empty, dout_exp, full_exp, empty_exp);
        end
    endtask

    task automatic step(input logic we, input logic lfd, input logic [7:0] din, input logic re,
                        input logic srst);
        write_en = we; lfd_state = lfd; data_in = din; read_en = re; soft_rst = srst;
        @(posedge clk);
        #1;
        write_en = 1'b0; lfd_state = 1'b0; read_en = 1'b0; soft_rst = 1'b0;
    endtask

    initial begin
        tbl[0]  = mk(1, 1, 8'h0C, 0, 0, 8'h00, 0, 0);
        tbl[1]  = mk(1, 0, 8'h11, 0, 0, 8'h00, 0, 0);
        tbl[2]  = mk(1, 0, 8'h22, 0, 0, 8'h00, 0, 0);
        tbl[3]  = mk(1, 0, 8'h33, 0, 0, 8'h00, 0, 0);
        tbl[4]  = mk(1, 0, 8'h0C, 0, 0, 8'h00, 0, 0);
        tbl[5]  = mk(0, 0, 8'h00, 1, 0, 8'h0C, 0, 0);
        tbl[6]  = mk(0, 0, 8'h00, 1, 0, 8'h11, 0, 0);
        tbl[7]  = mk(0, 0, 8'h00, 1, 0, 8'h22, 0, 0);
        tbl[8]  = mk(0, 0, 8'h00, 1, 0, 8'h33, 0, 0);
        tbl[9]  = mk(0, 0, 8'h00, 1, 0, 8'h0C, 0, 1);
        tbl[10] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 1);
        tbl[11] = mk(1, 0, 8'h5A, 1, 0, 8'h00, 0, 0);
        tbl[12] = mk(0, 0, 8'h00, 1, 0, 8'h5A, 0, 1);
        tbl[13] = mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 1);

        #1;
        check("reset_state", 8'h00, 1'b0, 1'b1);
        #13;
        reset_in = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].we, tbl[i].lfd, tbl[i].din, tbl[i].re, tbl[i].srst);
            check($sformatf("table[%0d]", i), tbl[i].dout, tbl[i].full, tbl[i].empty);
        end

        // 17 writes into 16 entries: last one must be dropped.
        for (int i = 0; i < 17; i++) begin
            step(1, 0, 8'hA0 + 8'(i), 0, 0);
            check($sformatf("fill[%0d]", i), 8'h00, (i >= 15), 1'b0);
        end
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 8'h00, 1, 0);
            check($sformatf("drain[%0d]", i), 8'hA0 + 8'(i), 1'b0, (i == 15));
        end

        // Simultaneous push/pop while full pops only.
        for (int i = 0; i < 16; i++) step(1, 0, 8'hB0 + 8'(i), 0, 0);
        check("refill_full", 8'h00, 1'b1, 1'b0);
        step(1, 0, 8'hFF, 1, 0);
        check("full_wr_rd", 8'hB0, 1'b0, 1'b0);
        for (int i = 1; i < 16; i++) begin
            step(0, 0, 8'h00, 1, 0);
            check($sformatf("drain15[%0d]", i), 8'hB0 + 8'(i), 1'b0, (i == 15));
        end
        step(0, 0, 8'h00, 1, 0);
        check("read_empty", 8'h00, 1'b0, 1'b1);

        // Streaming through the pointer wrap.
        step(1, 0, 8'h00, 0, 0);
        check("wrap_first", 8'h00, 1'b0, 1'b0);
        for (int i = 1; i < 40; i++) begin
            step(1, 0, 8'(i), 1, 0);
            check($sformatf("wrap[%0d]", i), 8'(i - 1), 1'b0, 1'b0);
        end
        step(0, 0, 8'h00, 1, 0);
        check("wrap_last", 8'd39, 1'b0, 1'b1);

        // Soft reset mid-packet clears pkt_cnt, so data_out must not hold afterwards.
        step(1, 1, 8'h14, 0, 0);
        for (int i = 1; i < 5; i++) step(1, 0, 8'(i), 0, 0);
        step(0, 0, 8'h00, 1, 0);
        check("srst_hdr", 8'h14, 1'b0, 1'b0);
        step(1, 0, 8'hEE, 1, 1);
        check("srst_flush", 8'h00, 1'b0, 1'b1);
        step(0, 0, 8'h00, 0, 0);
        check("srst_idle", 8'h00, 1'b0, 1'b1);
        step(1, 0, 8'h77, 0, 0);
        check("srst_wr", 8'h00, 1'b0, 1'b0);
        step(0, 0, 8'h00, 1, 0);
        check("srst_rd", 8'h77, 1'b0, 1'b1);
        step(0, 0, 8'h00, 0, 0);
        check("srst_pkt0", 8'h00, 1'b0, 1'b1);

        // Asynchronous hard reset mid-packet.
        step(1, 1, 8'h08, 0, 0);
        step(1, 0, 8'h01, 0, 0);
        step(1, 0, 8'h02, 0, 0);
        step(0, 0, 8'h00, 1, 0);
        check("pre_reset", 8'h08, 1'b0, 1'b0);
        #2;
        reset_in = 1'b1;
        #1;
        check("async_reset", 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        reset_in = 1'b0;
        @(posedge clk);
        #1;
        step(1, 0, 8'h42, 0, 0);
        check("post_reset_wr", 8'h00, 1'b0, 1'b0);
        step(0, 0, 8'h00, 1, 0);
        check("post_reset_rd", 8'h42, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
